// File: rtl/block_dequantizer.sv
// Block dequantizer: multiplies an 8x8 block of signed coefficients by a
// loadable unsigned quantization table, LANES products per cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_block/in_valid/in_ready     64 x COEF_W raster block in, valid/ready
//   q_wr_en/q_wr_addr/q_wr_data    serial table write, q_wr_ready accepts
//   out_block/out_valid/out_ready  64 x OUT_W result out, valid/ready
//   busy                     high while computing or holding a result
module block_dequantizer #(
    parameter int COEF_W = 8,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16,
    parameter int LANES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*COEF_W-1:0]  in_block,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  q_wr_en,
    input  logic [5:0]            q_wr_addr,
    input  logic [Q_W-1:0]        q_wr_data,
    output logic                  q_wr_ready,
    output logic [64*OUT_W-1:0]   out_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int GROUPS = 64 / LANES;
    localparam int K_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [K_W-1:0]    k;
    logic [COEF_W-1:0] coef_q   [64];
    logic [Q_W-1:0]    q_tab    [64];
    logic [OUT_W-1:0]  out_arr  [64];
    logic [5:0]        lane_idx [LANES];
    logic [OUT_W-1:0]  prod     [LANES];
    logic              last_grp;

    assign last_grp = (k == K_W'(GROUPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        q_wr_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready   = 1'b1;
                q_wr_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_grp) state_nx = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Coefficient is sign-extended and the table entry zero-extended to
    // OUT_W; the low OUT_W bits of that product equal the exact signed
    // result because the full range fits in OUT_W.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 6'(int'(k) * LANES + l);
            prod[l] =
                {{(OUT_W-COEF_W){coef_q[lane_idx[l]][COEF_W-1]}},
                 coef_q[lane_idx[l]]} *
                {{(OUT_W-Q_W){1'b0}}, q_tab[lane_idx[l]]};
        end
    end

    // Table writes and block capture share the IDLE edge; the table is
    // only read in CALC, so a same-edge write is seen by that block.
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            for (int j = 0; j < 64; j++) begin
                coef_q[j]  <= '0;
                q_tab[j]   <= Q_W'(1);
                out_arr[j] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (q_wr_en) q_tab[q_wr_addr] <= q_wr_data;
                    if (in_valid) begin
                        for (int j = 0; j < 64; j++) begin
                            coef_q[j] <= in_block[j*COEF_W +: COEF_W];
                        end
                        k <= '0;
                    end
                end
                CALC: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_arr[lane_idx[l]] <= prod[l];
                    end
                    k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 64; g++) begin : g_out
        assign out_block[g*OUT_W +: OUT_W] = out_arr[g];
    end

endmodule

// File: tb/tb_block_dequantizer.sv
// Directed bench for block_dequantizer: table-driven single-product
// vectors plus sequences for latency, stall, table lockout, reset, streaming.
module tb_block_dequantizer;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [511:0]  in_block = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          q_wr_en = 1'b0;
    logic [5:0]    q_wr_addr = '0;
    logic [7:0]    q_wr_data = '0;
    logic          q_wr_ready;
    logic [1023:0] out_block;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    block_dequantizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_block   (in_block),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .q_wr_en    (q_wr_en),
        .q_wr_addr  (q_wr_addr),
        .q_wr_data  (q_wr_data),
        .q_wr_ready (q_wr_ready),
        .out_block  (out_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0]   exp_arr [64];
    logic [511:0]  blk;

    task automatic chk_block(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int j = 0; j < 64; j++) begin
            if (out_block[j*16 +: 16] !== exp_arr[j]) begin
                bad++;
                if (first < 0) first = j;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d entries wrong, first j=%0d got %h expected %h",
                     name, bad, first, out_block[first*16 +: 16],
                     exp_arr[first]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write_q(input logic [5:0] a, input logic [7:0] d);
        q_wr_en = 1'b1;
        q_wr_addr = a;
        q_wr_data = d;
        @(posedge clk);
        #1;
        q_wr_en = 1'b0;
    endtask

    task automatic send(input logic [511:0] b, input bit hold,
                        output int t);
        logic r;
        int n;
        in_block = b;
        in_valid = 1'b1;
        n = 0;
        t = -1;
        while (n < 60) begin
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (r) begin
                t = cyc;
                break;
            end
        end
        if (!hold) in_valid = 1'b0;
        if (t < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_valid_low", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [7:0]  coef;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    logic [1023:0] exp6 [4];
    int nout = 0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (nout < 4) chk("stream_block", 32'(out_block == exp6[nout]), 32'd1);
            nout++;
        end
    end

    initial begin
        int t;
        int ta [4];
        logic [7:0] c;

        vecs[0] = '{6'd0,  8'h7F, 8'hFF, 16'd32385};
        vecs[1] = '{6'd63, 8'h80, 8'hFF, 16'h8080};
        vecs[2] = '{6'd10, 8'hFF, 8'd3,  16'hFFFD};
        vecs[3] = '{6'd20, 8'h00, 8'd200, 16'h0000};
        vecs[4] = '{6'd33, 8'd5,  8'd7,  16'h0023};
        vecs[5] = '{6'd47, 8'hF6, 8'd100, 16'hFC18};
        vecs[6] = '{6'd7,  8'h80, 8'd1,  16'hFF80};
        vecs[7] = '{6'd56, 8'h01, 8'd128, 16'h0080};

        // 1: reset state, identity table, latency
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_q_wr_ready", 32'(q_wr_ready), 32'd1);
        chk("rst_out_zero", 32'(out_block == '0), 32'd1);
        for (int j = 0; j < 64; j++) begin
            blk[j*8 +: 8] = 8'(j - 32);
            exp_arr[j] = 16'(j - 32);
        end
        send(blk, 1'b0, t);
        chk("calc_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) chk("latency_7_low", 32'(out_valid), 32'd0);
            if (i == 8) chk("latency_8_high", 32'(out_valid), 32'd1);
        end
        chk_block("identity_block");
        handoff();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // table-driven single-entry products
        foreach (vecs[v]) begin
            do_reset();
            write_q(vecs[v].addr, vecs[v].q);
            blk = {64{vecs[v].coef}};
            send(blk, 1'b0, t);
            wait_valid();
            chk($sformatf("vec%0d_prod", v),
                32'(out_block[int'(vecs[v].addr)*16 +: 16]),
                32'(vecs[v].exp));
            chk($sformatf("vec%0d_nbr", v),
                32'(out_block[((int'(vecs[v].addr) + 1) % 64)*16 +: 16]),
                32'({{8{vecs[v].coef[7]}}, vecs[v].coef}));
            handoff();
        end

        // 2: full table q[j]=j+1, all coefs -128
        do_reset();
        for (int j = 0; j < 64; j++) write_q(6'(j), 8'(j + 1));
        blk = {64{8'h80}};
        for (int j = 0; j < 64; j++) exp_arr[j] = 16'(-128 * (j + 1));
        send(blk, 1'b0, t);
        wait_valid();
        chk_block("ramp_table_block");
        chk("out63_e000", 32'(out_block[63*16 +: 16]), 32'h0000E000);
        handoff();

        // 3: stall in HOLD for 20 cycles
        blk = {64{8'h03}};
        for (int j = 0; j < 64; j++) exp_arr[j] = 16'(3 * (j + 1));
        send(blk, 1'b0, t);
        wait_valid();
        in_block = {64{8'h11}};
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        chk_block("hold_block_stable");
        in_valid = 1'b0;
        handoff();
        chk_block("block_kept_after_handoff");

        // 4: table write during CALC is ignored
        blk = {64{8'h02}};
        for (int j = 0; j < 64; j++) exp_arr[j] = 16'(2 * (j + 1));
        send(blk, 1'b0, t);
        q_wr_en = 1'b1;
        q_wr_addr = 6'd0;
        q_wr_data = 8'd9;
        chk("calc_q_wr_ready", 32'(q_wr_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        q_wr_en = 1'b0;
        wait_valid();
        chk_block("calc_write_ignored");
        handoff();
        send(blk, 1'b0, t);
        wait_valid();
        chk("q0_unchanged", 32'(out_block[15:0]), 32'd2);
        handoff();

        // 5: reset at 4th CALC edge
        blk = {64{8'h05}};
        send(blk, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_zero", 32'(out_block == '0), 32'd1);
        for (int j = 0; j < 64; j++) begin
            blk[j*8 +: 8] = 8'(j - 32);
            exp_arr[j] = 16'(j - 32);
        end
        send(blk, 1'b0, t);
        wait_valid();
        chk_block("midrst_table_identity");
        handoff();

        // 6: back-to-back streaming
        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 64; j++) begin
                c = 8'(b * 37 + j * 5 - 100);
                exp6[b][j*16 +: 16] = {{8{c[7]}}, c};
            end
        end
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 64; j++) blk[j*8 +: 8] = 8'(b * 37 + j * 5 - 100);
            send(blk, 1'b1, ta[b]);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30 && nout < 4; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(nout), 32'd4);
        for (int b = 1; b < 4; b++) begin
            chk($sformatf("stream_period%0d", b), 32'(ta[b] - ta[b-1]), 32'd10);
        end
        mon_en = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
